// File: rtl/trellis_error_flag_checker_if.sv
// Sample/decision handshake bundle for trellis_error_flag_checker.
// The master drives samples and candidate sequences; the slave returns the decision.
interface trellis_error_flag_checker_if #(
  parameter int seq_length              = 3,
  parameter int est_err_bitwidth        = 9,
  parameter int num_of_trellis_patterns = 3
);
  localparam int NC = 2 * num_of_trellis_patterns;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  logic [NC-1:0][seq_length-1:0][est_err_bitwidth-1:0] injection_error_seqs;
  logic                                                in_valid;
  logic        [est_err_bitwidth-1:0]                  in_err;
  logic                                                in_ready;
  logic                                                out_valid;
  logic                                                out_ready;
  logic                                                flag_ena;
  logic        [IW-1:0]                                flag_idx;

  modport master (
    output injection_error_seqs, in_valid, in_err, out_ready,
    input  in_ready, out_valid, flag_ena, flag_idx
  );

  modport slave (
    input  injection_error_seqs, in_valid, in_err, out_ready,
    output in_ready, out_valid, flag_ena, flag_idx
  );
endinterface

// File: rtl/trellis_error_flag_checker.sv
// Accumulates |residual| and |residual - candidate| over a window, then scans the
// candidates serially and flags the one that strictly beats the no-injection baseline.
module trellis_error_flag_checker #(
  parameter int seq_length              = 3,
  parameter int est_err_bitwidth        = 9,
  parameter int num_of_trellis_patterns = 3
) (
  input  logic                           clk,
  input  logic                           rstb,
  trellis_error_flag_checker_if.slave    bus
);
  localparam int NC   = 2 * num_of_trellis_patterns;
  localparam int IW   = (NC > 1) ? $clog2(NC) : 1;
  localparam int SCW  = IW + 1;
  localparam int EW   = est_err_bitwidth;
  localparam int DW   = EW + 1;
  localparam int AW   = EW + 1 + $clog2(seq_length);
  localparam int CNTW = (seq_length > 1) ? $clog2(seq_length) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, COMPARE = 2'd2, HOLD = 2'd3} state_t;

  state_t                                  state_q;
  logic [NC-1:0][seq_length-1:0][EW-1:0]   snap_q;
  logic [AW-1:0]                           base_acc_q;
  logic [AW-1:0]                           cand_acc_q [NC];
  logic [CNTW-1:0]                         smp_cnt_q;
  logic [SCW-1:0]                          scan_cnt_q;
  logic [AW-1:0]                           best_q;
  logic [IW-1:0]                           best_idx_q;
  logic                                    best_ena_q;
  logic                                    in_ready_q;
  logic                                    out_valid_q;
  logic                                    flag_ena_q;
  logic [IW-1:0]                           flag_idx_q;

  logic                                    accept_s;
  logic [AW-1:0]                           base_term_s;
  logic [AW-1:0]                           cand_term_s [NC];
  logic [IW-1:0]                           scan_idx_s;

  // Magnitude of a sign-extended difference; the extra bit keeps -2^(EW) representable.
  function automatic logic [DW-1:0] abs_f(input logic [DW-1:0] v);
    abs_f = v[DW-1] ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign accept_s   = bus.in_valid && in_ready_q;
  assign scan_idx_s = scan_cnt_q[IW-1:0];

  // Per-sample contributions; in IDLE the live sequences are used since the snapshot loads on the same edge.
  always_comb begin
    logic [DW-1:0] smp_ext_v;
    logic [DW-1:0] ref_ext_v;
    logic [EW-1:0] ref_v;
    smp_ext_v   = {bus.in_err[EW-1], bus.in_err};
    base_term_s = AW'(abs_f(smp_ext_v));
    for (int k = 0; k < NC; k++) begin
      if (state_q == IDLE) begin
        ref_v = bus.injection_error_seqs[k][smp_cnt_q];
      end else begin
        ref_v = snap_q[k][smp_cnt_q];
      end
      ref_ext_v      = {ref_v[EW-1], ref_v};
      cand_term_s[k] = AW'(abs_f(smp_ext_v - ref_ext_v));
    end
  end

  // Control FSM, accumulators, serial compare and registered decision outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      base_acc_q  <= '0;
      for (int k = 0; k < NC; k++) cand_acc_q[k] <= '0;
      smp_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      best_ena_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      flag_ena_q  <= 1'b0;
      flag_idx_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            snap_q     <= bus.injection_error_seqs;
            base_acc_q <= base_term_s;
            for (int k = 0; k < NC; k++) cand_acc_q[k] <= cand_term_s[k];
            if (seq_length == 1) begin
              state_q    <= COMPARE;
              in_ready_q <= 1'b0;
              best_q     <= base_term_s;
              best_idx_q <= '0;
              best_ena_q <= 1'b0;
              scan_cnt_q <= '0;
              smp_cnt_q  <= '0;
            end else begin
              state_q   <= ACCUM;
              smp_cnt_q <= CNTW'(1);
            end
          end
        end
        ACCUM: begin
          if (accept_s) begin
            base_acc_q <= base_acc_q + base_term_s;
            for (int k = 0; k < NC; k++) cand_acc_q[k] <= cand_acc_q[k] + cand_term_s[k];
            if (smp_cnt_q == CNTW'(seq_length - 1)) begin
              state_q    <= COMPARE;
              in_ready_q <= 1'b0;
              best_q     <= base_acc_q + base_term_s;
              best_idx_q <= '0;
              best_ena_q <= 1'b0;
              scan_cnt_q <= '0;
              smp_cnt_q  <= '0;
            end else begin
              smp_cnt_q <= smp_cnt_q + CNTW'(1);
            end
          end
        end
        COMPARE: begin
          // Strict less-than keeps the earliest entry on ties, baseline first.
          if (scan_cnt_q < SCW'(NC)) begin
            if (cand_acc_q[scan_idx_s] < best_q) begin
              best_q     <= cand_acc_q[scan_idx_s];
              best_idx_q <= scan_idx_s;
              best_ena_q <= 1'b1;
            end
            scan_cnt_q <= scan_cnt_q + SCW'(1);
          end else begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            flag_ena_q  <= best_ena_q;
            flag_idx_q  <= best_idx_q;
            scan_cnt_q  <= '0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            flag_ena_q  <= 1'b0;
            flag_idx_q  <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          flag_ena_q  <= 1'b0;
          flag_idx_q  <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.flag_ena  = flag_ena_q;
  assign bus.flag_idx  = flag_idx_q;
endmodule

// File: tb/tb_trellis_error_flag_checker.sv
// Directed bench for trellis_error_flag_checker with default parameters.
module tb_trellis_error_flag_checker;
  logic clk;
  logic rstb;
  int   n_checks;
  int   n_fail;

  trellis_error_flag_checker_if #(.seq_length(3), .est_err_bitwidth(9), .num_of_trellis_patterns(3)) bus ();

  trellis_error_flag_checker #(.seq_length(3), .est_err_bitwidth(9), .num_of_trellis_patterns(3)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inj();
    bus.injection_error_seqs = '0;
  endtask

  task automatic set_seq(input int k, input int a0, input int a1, input int a2);
    bus.injection_error_seqs[k][0] = 9'(a0);
    bus.injection_error_seqs[k][1] = 9'(a1);
    bus.injection_error_seqs[k][2] = 9'(a2);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    check_eq("in_ready_when_sending", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_err   = 9'(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_outputs_idle(input string tag);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_flag_ena"},  32'(bus.flag_ena),  32'd0);
    check_eq({tag, "_flag_idx"},  32'(bus.flag_idx),  32'd0);
    check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  // Called #1 after the last accept edge: checks latency, decision, then releases it.
  task automatic finish_window(input string tag, input int exp_ena, input int exp_idx);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_latency"},  32'(n), 32'd7);
    check_eq({tag, "_flag_ena"}, 32'(bus.flag_ena), 32'(exp_ena));
    check_eq({tag, "_flag_idx"}, 32'(bus.flag_idx), 32'(exp_idx));
    check_eq({tag, "_in_ready_hold"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_outputs_idle({tag, "_release"});
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rstb         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_err   = '0;
    bus.out_ready = 1'b0;
    clear_inj();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_idle("reset");
    @(negedge clk);
    rstb = 1'b1;

    // Normal-polarity exact match on pattern 1; live sequences change after snapshot.
    clear_inj();
    set_seq(2, 4, -2, 0);
    send(4);
    clear_inj();
    send(-2);
    send(0);
    finish_window("match2", 1, 2);

    // All-zero candidates tie with the baseline.
    clear_inj();
    send(5);
    send(3);
    send(-1);
    finish_window("tie_base", 0, 0);

    // Two equal winners: earliest index, with idle gaps inside the window.
    clear_inj();
    set_seq(1, 1, 1, 1);
    set_seq(3, 1, 1, 1);
    send(1);
    repeat (3) @(posedge clk);
    send(1);
    repeat (2) @(posedge clk);
    send(1);
    finish_window("early_tie", 1, 1);

    // Last candidate index wins against a close neighbour.
    clear_inj();
    set_seq(4, -3, -3, -2);
    set_seq(5, -3, -3, -3);
    send(-3);
    send(-3);
    send(-3);
    finish_window("last_idx", 1, 5);

    // Downstream stall: decision held stable with in_ready low.
    clear_inj();
    set_seq(2, 4, -2, 0);
    send(4);
    send(-2);
    send(0);
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_flag_idx",  32'(bus.flag_idx),  32'd2);
      check_eq("stall_in_ready",  32'(bus.in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_outputs_idle("stall_release");

    // Reset mid-window discards the partial accumulation.
    clear_inj();
    set_seq(2, 4, -2, 0);
    send(4);
    send(-2);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    check_outputs_idle("mid_reset");
    @(negedge clk);
    rstb = 1'b1;
    send(4);
    send(-2);
    send(0);
    finish_window("after_reset", 1, 2);

    // Extreme negative samples against extreme positive candidate: no wrap.
    clear_inj();
    set_seq(0, 255, 255, 255);
    send(-256);
    send(-256);
    send(-256);
    repeat (3) @(posedge clk);
    #1;
    check_eq("cand0_no_wrap", 32'(dut.cand_acc_q[0]), 32'd1533);
    check_eq("base_no_wrap",  32'(dut.base_acc_q),    32'd768);
    repeat (4) @(posedge clk);
    #1;
    check_eq("extreme_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("extreme_flag_ena",  32'(bus.flag_ena),  32'd0);
    check_eq("extreme_flag_idx",  32'(bus.flag_idx),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
